odd_count_checker: RTL and testbench
====================================

ODD_COUNT_CHECKER -- requirements
Module: odd_count_checker

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the data width of the checked count stream.
REQ-002 Parameter LOCK_CNT, default 4, range 1..15, SHALL set the number of consecutive correct samples required to declare lock.
REQ-003 Parameter ERR_W, default 16, SHALL set the error counter width.
REQ-004 Clk, input, 1, SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 Rst_l, input, 1, SHALL be the asynchronous, active-low reset.
REQ-006 Count_In, input, WIDTH, SHALL carry the sample under check, which is expected to be the odd sequence 1, 3, 5, ...
REQ-007 Valid_In, input, 1, SHALL qualify Count_In; samples are taken only when it is high.
REQ-008 Clear_Err, input, 1, SHALL be a synchronous clear of Err_Sticky and Err_Count.
REQ-009 Locked, output, 1, SHALL be high while in state LOCKED.
REQ-010 Err, output, 1, SHALL be a one-cycle error pulse.
REQ-011 Err_Sticky, output, 1, SHALL hold high once an error occurs, until cleared.
REQ-012 Err_Count, output, ERR_W, SHALL be a saturating count of errors.
REQ-013 Expected, output, WIDTH, SHALL give the next expected sample value.

Function
REQ-014 The FSM SHALL have three states: HUNT, SYNC and LOCKED; all outputs SHALL be registered.
REQ-015 In HUNT, a valid odd sample SHALL set Expected to sample+2 and good_cnt to 1, and move to SYNC; a valid even sample SHALL leave the state in HUNT.
REQ-016 In SYNC, a valid sample equal to Expected SHALL increment good_cnt and add 2 to Expected; when good_cnt reaches LOCK_CNT the FSM SHALL move to LOCKED.
REQ-017 In SYNC, a mismatching odd sample SHALL reload Expected to sample+2 and good_cnt to 1; a mismatching even sample SHALL move to HUNT; neither case SHALL count as an error.
REQ-018 If LOCK_CNT equals 1, HUNT SHALL move directly to LOCKED on the first valid odd sample.
REQ-019 In LOCKED, a matching sample SHALL add 2 to Expected and keep the FSM in LOCKED.
REQ-020 In LOCKED, a mismatching sample SHALL pulse Err for one cycle, set Err_Sticky and increment Err_Count; the FSM SHALL then resync as in REQ-017 (odd sample: SYNC, even sample: HUNT).
REQ-021 Err and Locked SHALL change the cycle after the sample edge, giving a latency of 1.
REQ-022 Expected arithmetic SHALL be modulo 2^WIDTH, so that {WIDTH{1}} is followed by 1 as a match.
REQ-023 When Valid_In is low, state, Expected, good_cnt and the error registers SHALL hold their values, and Err SHALL be 0.
REQ-024 Err_Count SHALL saturate at all-ones.
REQ-025 If Clear_Err and a new error occur in the same cycle, the error SHALL win: Err_Count becomes 1 and Err_Sticky becomes 1.

Reset
REQ-026 Asserting Rst_l low SHALL immediately force: state HUNT, Locked 0, Err 0, Err_Sticky 0, Err_Count 0, Expected 1, good_cnt 0.
REQ-027 Reset asserted mid-stream SHALL discard lock; after release, relock SHALL require LOCK_CNT fresh correct samples.

Configuration
REQ-028 Macro ODD_CHECK_PARITY_ERR_EN SHALL control parity-error detection.
- Defined: any valid even sample in any state SHALL also pulse Err, set Err_Sticky and increment Err_Count, counted once per sample.
- Not defined: even samples outside LOCKED SHALL be silent; ports SHALL be unchanged.

Structure
REQ-029 Package odd_pkg SHALL hold the state enum typedef (HUNT/SYNC/LOCKED) and the default WIDTH, LOCK_CNT and ERR_W constants.
REQ-030 The saturating counter with clear and the clear-versus-increment priority SHALL be sub-module odd_err_counter, instantiated once.

Verification
REQ-031 Valid samples 1,3,5,7 with LOCK_CNT=4 -> Locked=1 the cycle after sample 7; Err never asserts.
REQ-032 Locked, Expected=9, sample 11 -> Err pulses once, Err_Count=1, Err_Sticky=1, FSM in SYNC, Expected=13.
REQ-033 Locked at 0xFFFFFFFD; samples 0xFFFFFFFF then 0x00000001 -> no Err, Locked stays 1.
REQ-034 Err_Count preloaded to 0xFFFF by 0xFFFF forced errors, then one more error -> Err_Count stays 0xFFFF; Clear_Err with a simultaneous error -> Err_Count=1.
REQ-035 Rst_l pulsed low while Locked -> Locked=0 and Expected=1 without a clock edge; after release, 4 good samples are needed to relock.
REQ-036 With ODD_CHECK_PARITY_ERR_EN, sample 4 in HUNT -> Err pulses and Err_Count=1; without the macro, the same stimulus -> no Err.

Source files
------------

// File: rtl/odd_pkg.sv
// Shared types and default constants for the odd-sequence count checker.
package odd_pkg;

  // Default parameter values for the checker.
  localparam int unsigned DEF_WIDTH    = 32;
  localparam int unsigned DEF_LOCK_CNT = 4;
  localparam int unsigned DEF_ERR_W    = 16;

  // The good-sample counter only has to reach LOCK_CNT, which is at most 15.
  localparam int unsigned GOOD_CNT_W = 4;

  // Lock-acquisition state machine.
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } odd_state_e;

endpackage : odd_pkg

// File: rtl/odd_err_counter.sv
// Saturating error counter with sticky flag and synchronous clear.
// A new error in the same cycle as a clear wins: the count restarts at 1.
module odd_err_counter
  import odd_pkg::*;
#(
  parameter int unsigned ERR_W = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic             sticky,
  output logic [ERR_W-1:0] count
);

  logic             sticky_q, sticky_d;
  logic [ERR_W-1:0] count_q,  count_d;

  // Next-state: increment (saturating) or restart at 1 on error, else clear.
  always_comb begin
    sticky_d = sticky_q;
    count_d  = count_q;
    if (inc) begin
      sticky_d = 1'b1;
      if (clear) begin
        count_d = ERR_W'(1);
      end else if (count_q != {ERR_W{1'b1}}) begin
        count_d = count_q + ERR_W'(1);
      end
    end else if (clear) begin
      sticky_d = 1'b0;
      count_d  = '0;
    end
  end

  // Counter registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
      count_q  <= '0;
    end else begin
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

  assign sticky = sticky_q;
  assign count  = count_q;

endmodule : odd_err_counter

// File: rtl/odd_count_checker.sv
// Checks that a qualified sample stream follows the odd sequence 1, 3, 5, ...
// Acquires lock after LOCK_CNT consecutive correct samples and flags
// mismatches once locked. All outputs are registered (latency 1).
// Optional feature macro: ODD_CHECK_PARITY_ERR_EN -- when defined, every valid
// even sample, in any state, is also reported as an error (once per sample).
module odd_count_checker
  import odd_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned LOCK_CNT = DEF_LOCK_CNT,
  parameter int unsigned ERR_W    = DEF_ERR_W
) (
  input  logic             Clk,
  input  logic             Rst_l,
  input  logic [WIDTH-1:0] Count_In,
  input  logic             Valid_In,
  input  logic             Clear_Err,
  output logic             Locked,
  output logic             Err,
  output logic             Err_Sticky,
  output logic [ERR_W-1:0] Err_Count,
  output logic [WIDTH-1:0] Expected
);

  localparam logic [GOOD_CNT_W-1:0] LOCK_CNT_L = GOOD_CNT_W'(LOCK_CNT);
  localparam logic [WIDTH-1:0]      ONE        = WIDTH'(1);
  localparam logic [WIDTH-1:0]      TWO        = WIDTH'(2);

  odd_state_e            state_q,    state_d;
  logic [WIDTH-1:0]      expected_q, expected_d;
  logic [GOOD_CNT_W-1:0] good_cnt_q, good_cnt_d;
  logic                  err_q,      err_d;
  logic                  locked_q,   locked_d;

  logic                  sample_odd;
  logic                  sample_match;
  logic [GOOD_CNT_W-1:0] good_inc;
  logic                  parity_err;
  logic                  lock_err;

  assign sample_odd   = Count_In[0];
  assign sample_match = (Count_In == expected_q);
  assign good_inc     = good_cnt_q + GOOD_CNT_W'(1);

`ifdef ODD_CHECK_PARITY_ERR_EN
  // Any valid even sample is a parity error regardless of state.
  assign parity_err = Valid_In & ~Count_In[0];
`else
  assign parity_err = 1'b0;
`endif

  // Next-state, expected-value tracking and error detection.
  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    good_cnt_d = good_cnt_q;
    lock_err   = 1'b0;
    if (Valid_In) begin
      case (state_q)
        HUNT: begin
          if (sample_odd) begin
            expected_d = Count_In + TWO;
            good_cnt_d = GOOD_CNT_W'(1);
            state_d    = (LOCK_CNT_L <= GOOD_CNT_W'(1)) ? LOCKED : SYNC;
          end
        end
        SYNC: begin
          if (sample_match) begin
            expected_d = expected_q + TWO;
            good_cnt_d = good_inc;
            if (good_inc >= LOCK_CNT_L) begin
              state_d = LOCKED;
            end
          end else if (sample_odd) begin
            // Restart the run from this sample; not an error before lock.
            expected_d = Count_In + TWO;
            good_cnt_d = GOOD_CNT_W'(1);
          end else begin
            good_cnt_d = '0;
            state_d    = HUNT;
          end
        end
        LOCKED: begin
          if (sample_match) begin
            expected_d = expected_q + TWO;
          end else begin
            lock_err = 1'b1;
            if (sample_odd) begin
              expected_d = Count_In + TWO;
              good_cnt_d = GOOD_CNT_W'(1);
              state_d    = SYNC;
            end else begin
              good_cnt_d = '0;
              state_d    = HUNT;
            end
          end
        end
        default: begin
          state_d    = HUNT;
          good_cnt_d = '0;
        end
      endcase
    end
    // An even sample in LOCKED is both a mismatch and a parity error; OR
    // them so it is counted only once.
    err_d    = lock_err | parity_err;
    locked_d = (state_d == LOCKED);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge Clk or negedge Rst_l) begin
    if (!Rst_l) begin
      state_q    <= HUNT;
      expected_q <= ONE;
      good_cnt_q <= '0;
      err_q      <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      good_cnt_q <= good_cnt_d;
      err_q      <= err_d;
      locked_q   <= locked_d;
    end
  end

  odd_err_counter #(
    .ERR_W (ERR_W)
  ) u_err_counter (
    .clk    (Clk),
    .rst_n  (Rst_l),
    .clear  (Clear_Err),
    .inc    (err_d),
    .sticky (Err_Sticky),
    .count  (Err_Count)
  );

  assign Locked   = locked_q;
  assign Err      = err_q;
  assign Expected = expected_q;

endmodule : odd_count_checker

// File: tb/tb_odd_count_checker.sv
// Self-checking bench for odd_count_checker. A run-length model of the odd
// sequence is compared against the DUT every cycle, and directed literal
// checks pin the key scenarios. ERR_W is reduced so the saturation scenario
// fits in a short run.
module tb_odd_count_checker;

  localparam int W  = 32;
  localparam int LC = 4;
  localparam int EW = 8;
`ifdef ODD_CHECK_PARITY_ERR_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int SAT = (1 << EW) - 1;

  logic          Clk;
  logic          Rst_l;
  logic [W-1:0]  Count_In;
  logic          Valid_In;
  logic          Clear_Err;
  logic          Locked;
  logic          Err;
  logic          Err_Sticky;
  logic [EW-1:0] Err_Count;
  logic [W-1:0]  Expected;

  odd_count_checker #(
    .WIDTH    (W),
    .LOCK_CNT (LC),
    .ERR_W    (EW)
  ) dut (
    .Clk        (Clk),
    .Rst_l      (Rst_l),
    .Count_In   (Count_In),
    .Valid_In   (Valid_In),
    .Clear_Err  (Clear_Err),
    .Locked     (Locked),
    .Err        (Err),
    .Err_Sticky (Err_Sticky),
    .Err_Count  (Err_Count),
    .Expected   (Expected)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: length of the current run of consecutive odd samples each two
  // above the previous; lock holds while the run is at least LC long.
  int           m_run;
  logic [W-1:0] m_exp;
  bit           m_err;
  bit           m_locked;
  bit           m_sticky;
  int           m_cnt;
  bit           cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_run    = 0;
    m_exp    = W'(1);
    m_err    = 1'b0;
    m_locked = 1'b0;
    m_sticky = 1'b0;
    m_cnt    = 0;
  endfunction

  function automatic void model_step(input bit v, input logic [W-1:0] s, input bit clr);
    bit e;
    e = v && (((m_run >= LC) && (s != m_exp)) || (PAR && !s[0]));
    if (v) begin
      if (s[0]) begin
        if (m_run > 0 && s == m_exp) m_run = (m_run < LC) ? m_run + 1 : m_run;
        else                         m_run = 1;
        m_exp = s + W'(2);
      end else begin
        m_run = 0;
      end
    end
    if (e) begin
      m_sticky = 1'b1;
      m_cnt    = clr ? 1 : ((m_cnt == SAT) ? SAT : m_cnt + 1);
    end else if (clr) begin
      m_sticky = 1'b0;
      m_cnt    = 0;
    end
    m_err    = e;
    m_locked = (m_run >= LC);
  endfunction

  // Apply one cycle of stimulus, advance the model, return at the negedge.
  task automatic step(input bit v, input logic [W-1:0] s, input bit clr);
    Valid_In  = v;
    Count_In  = s;
    Clear_Err = clr;
    @(posedge Clk);
    model_step(v, s, clr);
    @(negedge Clk);
    $display("txn valid=%0d sample=0x%08h clr=%0d -> locked=%0d err=%0d sticky=%0d cnt=%0d exp=0x%08h",
             v, s, clr, Locked, Err, Err_Sticky, Err_Count, Expected);
  endtask

  // Compare every cycle against the model while out of reset.
  always @(negedge Clk) begin
    if (cmp_en && Rst_l) begin
      chk("m_locked",   64'(Locked),     64'(m_locked));
      chk("m_err",      64'(Err),        64'(m_err));
      chk("m_sticky",   64'(Err_Sticky), 64'(m_sticky));
      chk("m_count",    64'(Err_Count),  64'(m_cnt));
      chk("m_expected", 64'(Expected),   64'(m_exp));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] nxt;
    Rst_l = 1'b0; Valid_In = 1'b0; Count_In = '0; Clear_Err = 1'b0;
    model_reset();
    repeat (2) @(negedge Clk);
    chk("rst_locked",   64'(Locked),     64'd0);
    chk("rst_err",      64'(Err),        64'd0);
    chk("rst_sticky",   64'(Err_Sticky), 64'd0);
    chk("rst_count",    64'(Err_Count),  64'd0);
    chk("rst_expected", 64'(Expected),   64'd1);
    Rst_l  = 1'b1;
    cmp_en = 1'b1;

    // Idle, then acquire lock on 1,3,5,7.
    step(0, '0, 0); step(0, '0, 0);
    step(1, 32'd1, 0); step(1, 32'd3, 0); step(1, 32'd5, 0);
    chk("lock_early", 64'(Locked), 64'd0);
    step(1, 32'd7, 0);
    chk("lock_7",     64'(Locked),   64'd1);
    chk("lock_7_exp", 64'(Expected), 64'd9);
    chk("lock_7_err", 64'(Err),      64'd0);

    // Valid low holds everything.
    step(0, 32'd100, 0); step(0, 32'd6, 0);
    chk("hold_locked", 64'(Locked),   64'd1);
    chk("hold_exp",    64'(Expected), 64'd9);

    // Mismatch while locked: expected 9, sample 11.
    step(1, 32'd11, 0);
    chk("mis_err",    64'(Err),        64'd1);
    chk("mis_cnt",    64'(Err_Count),  64'd1);
    chk("mis_sticky", 64'(Err_Sticky), 64'd1);
    chk("mis_locked", 64'(Locked),     64'd0);
    chk("mis_exp",    64'(Expected),   64'd13);
    step(0, '0, 0);
    chk("err_pulse", 64'(Err), 64'd0);

    // Relock, then an even sample while locked.
    step(1, 32'd13, 0); step(1, 32'd15, 0); step(1, 32'd17, 0);
    chk("relock", 64'(Locked), 64'd1);
    step(1, 32'd2, 0);
    chk("even_lock_err", 64'(Err),       64'd1);
    chk("even_lock_cnt", 64'(Err_Count), 64'd2);

    // Mismatches before lock are not errors (parity aside).
    step(1, 32'd21, 0); step(1, 32'd31, 0);
    chk("sync_reload_err", 64'(Err),      64'd0);
    chk("sync_reload_exp", 64'(Expected), 64'd33);
    step(1, 32'd40, 0);
    chk("sync_even_err", 64'(Err),       64'(PAR));
    chk("sync_even_cnt", 64'(Err_Count), 64'(2 + PAR));

    // Wrap-around of the expected value.
    step(1, 32'hFFFF_FFF7, 0); step(1, 32'hFFFF_FFF9, 0);
    step(1, 32'hFFFF_FFFB, 0); step(1, 32'hFFFF_FFFD, 0);
    chk("wrap_lock", 64'(Locked),   64'd1);
    chk("wrap_exp",  64'(Expected), 64'hFFFF_FFFF);
    step(1, 32'hFFFF_FFFF, 0);
    chk("wrap_err0",  64'(Err),      64'd0);
    chk("wrap_exp1",  64'(Expected), 64'd1);
    step(1, 32'd1, 0);
    chk("wrap_err1",   64'(Err),    64'd0);
    chk("wrap_locked", 64'(Locked), 64'd1);

    // Plain clear alongside a matching sample.
    step(1, 32'd3, 1);
    chk("clr_cnt",    64'(Err_Count),  64'd0);
    chk("clr_sticky", 64'(Err_Sticky), 64'd0);

    // Drive the counter to saturation: one forced error then relock each time.
    nxt = 32'd5;
    for (int i = 0; i < SAT + 1; i++) begin
      step(1, nxt + 32'd4, 0);
      step(1, nxt + 32'd6, 0);
      step(1, nxt + 32'd8, 0);
      step(1, nxt + 32'd10, 0);
      nxt = nxt + 32'd12;
      if (i == SAT - 1) chk("sat_reach", 64'(Err_Count), 64'(SAT));
    end
    chk("sat_hold", 64'(Err_Count), 64'(SAT));
    chk("sat_lock", 64'(Locked),    64'd1);
    // Clear together with a new error: the error wins.
    step(1, nxt + 32'd4, 1);
    chk("clr_err_cnt",    64'(Err_Count),  64'd1);
    chk("clr_err_sticky", 64'(Err_Sticky), 64'd1);
    chk("clr_err_err",    64'(Err),        64'd1);

    // Even sample in HUNT after reset.
    Rst_l = 1'b0; model_reset();
    @(negedge Clk);
    Rst_l = 1'b1;
    step(1, 32'd4, 0);
    chk("hunt_even_err", 64'(Err),       64'(PAR));
    chk("hunt_even_cnt", 64'(Err_Count), 64'(PAR));

    // Asynchronous reset while locked, then a fresh relock.
    step(1, 32'd1, 0); step(1, 32'd3, 0); step(1, 32'd5, 0); step(1, 32'd7, 0);
    chk("pre_rst_lock", 64'(Locked), 64'd1);
    #2;
    Rst_l = 1'b0; model_reset();
    #1;
    chk("async_locked", 64'(Locked),    64'd0);
    chk("async_exp",    64'(Expected),  64'd1);
    chk("async_cnt",    64'(Err_Count), 64'd0);
    @(negedge Clk);
    Rst_l = 1'b1;
    step(1, 32'd1, 0); step(1, 32'd3, 0); step(1, 32'd5, 0);
    chk("post_rst_early", 64'(Locked), 64'd0);
    step(1, 32'd7, 0);
    chk("post_rst_lock", 64'(Locked), 64'd1);
    step(0, '0, 0);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_odd_count_checker
